// File: rtl/rng_pkg.sv
// Shared constants for the Pong random number source: LFSR width,
// default seed, feedback tap positions and the next-state function.
// Optional build macro used by this slice: RANDOM_NUMBER_SEED_LOAD_EN.
package rng_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (Fibonacci form)
    localparam int unsigned TAP0 = 15;
    localparam int unsigned TAP1 = 13;
    localparam int unsigned TAP2 = 12;
    localparam int unsigned TAP3 = 10;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
        return {s[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with synchronous active-low reset.
// With RANDOM_NUMBER_SEED_LOAD_EN defined, a runtime seed can be loaded;
// a zero seed is replaced by the reset seed so the register never locks up.
module lfsr16
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              i_rst_n,
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
`endif
    output logic [LFSR_W-1:0] o_state
);

    // A zero seed would freeze the LFSR; fall back to the package default.
    localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? DEFAULT_SEED : SEED;

    logic [LFSR_W-1:0] r_state;

    // Advance every clock; reset (highest priority) or seed load override.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= SAFE_SEED;
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
        end else if (i_seed_load) begin
            r_state <= (i_seed == '0) ? SAFE_SEED : i_seed;
`endif
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/random_number_gen.sv
// Free-running pseudo-random source for the Pong game logic. The top 10
// LFSR bits are scaled into [0, max-1] and registered onto rand_out.
// Optional build macro: RANDOM_NUMBER_SEED_LOAD_EN adds seed_load/seed.
module random_number_gen
    import rng_pkg::*;
#(
    parameter int unsigned       OUT_W = 10,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
    input  logic             seed_load,
    input  logic [LFSR_W-1:0] seed,
`endif
    input  logic [OUT_W-1:0] max,
    output logic [OUT_W-1:0] rand_out
);

    localparam int unsigned FRAC_W = 10;
    localparam int unsigned PROD_W = FRAC_W + OUT_W;

    logic [LFSR_W-1:0] w_lfsr;
    logic [PROD_W-1:0] w_prod;
    logic [OUT_W-1:0]  w_scaled;
    logic              w_unused_lfsr_lo;
    logic [OUT_W-1:0]  r_rand;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk         (CLOCK_50),
        .i_rst_n     (reset_n),
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
        .i_seed_load (seed_load),
        .i_seed      (seed),
`endif
        .o_state     (w_lfsr)
    );

    // Fraction l[15:6]/1024 times max; the high part is always below max.
    assign w_prod           = PROD_W'(w_lfsr[LFSR_W-1:LFSR_W-FRAC_W]) * PROD_W'(max);
    assign w_scaled         = w_prod[PROD_W-1:FRAC_W];
    assign w_unused_lfsr_lo = ^w_lfsr[LFSR_W-FRAC_W-1:0];

    // Register the scaled value from the current LFSR state and max.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_rand <= '0;
        end else begin
            r_rand <= w_scaled;
        end
    end

    assign rand_out = r_rand;

endmodule

// File: tb/tb_random_number_gen.sv
// Directed self-checking bench for random_number_gen.
// Covers RANDOM_NUMBER_SEED_LOAD_EN when the macro is defined.
module tb_random_number_gen;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic [9:0]  max      = '0;
    logic [9:0]  rand_out;
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed      = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;
    logic [9:0]  rec [0:999];

    random_number_gen #(
        .OUT_W (10),
        .SEED  (16'hACE1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
        .seed_load(seed_load),
        .seed     (seed),
`endif
        .max      (max),
        .rand_out (rand_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [15:0] mdl_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [9:0] mdl_scale(input logic [15:0] s, input logic [9:0] m);
        logic [19:0] p;
        p = 20'(s[15:6]) * 20'(m);
        return p[19:10];
    endfunction

    task automatic step;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        m_lfsr = 16'hACE1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        max = 10'd8;
        step();
        step();
        checks++;
        if (rand_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_rand_out got %0d expected 0", rand_out);
        end
        checks++;
        if (dut.w_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_lfsr got %h expected ace1", dut.w_lfsr);
        end
    endtask

    task automatic test_first_values;
        reset_n = 1'b1;
        step();
        checks++;
        if (rand_out !== 10'd5) begin
            errors++;
            $display("FAIL first_max8 got %0d expected 5", rand_out);
        end
        checks++;
        if (dut.w_lfsr !== 16'h59C3) begin
            errors++;
            $display("FAIL first_lfsr got %h expected 59c3", dut.w_lfsr);
        end
        max = 10'd10;
        do_reset();
        step();
        checks++;
        if (rand_out !== 10'd6) begin
            errors++;
            $display("FAIL first_max10 got %0d expected 6", rand_out);
        end
        checks++;
        if (dut.w_lfsr !== 16'h59C3) begin
            errors++;
            $display("FAIL first_lfsr10 got %h expected 59c3", dut.w_lfsr);
        end
    endtask

    // Full period with max=480: model match, range bound, no zero state,
    // and the seed reappears exactly at advance 65535.
    task automatic test_range_period;
        logic [9:0] exp;
        max = 10'd480;
        do_reset();
        for (int n = 1; n <= 65535; n++) begin
            exp = mdl_scale(m_lfsr, max);
            step();
            m_lfsr = mdl_next(m_lfsr);
            checks++;
            if (rand_out !== exp || rand_out >= 10'd480) begin
                errors++;
                if (errors < 20)
                    $display("FAIL sweep_rand n=%0d got %0d expected %0d", n, rand_out, exp);
            end
            checks++;
            if (dut.w_lfsr === 16'h0000 || ((dut.w_lfsr === 16'hACE1) != (n == 65535))) begin
                errors++;
                if (errors < 20)
                    $display("FAIL period_lfsr n=%0d got %h", n, dut.w_lfsr);
            end
        end
    endtask

    task automatic test_zero_one_and_changes;
        logic [9:0] exp;
        logic [9:0] pats [0:5];
        pats[0] = 10'd0;   pats[1] = 10'd1;   pats[2] = 10'd1023;
        pats[3] = 10'd2;   pats[4] = 10'd640; pats[5] = 10'd3;
        for (int mi = 0; mi < 2; mi++) begin
            max = (mi == 0) ? 10'd0 : 10'd1;
            for (int n = 0; n < 300; n++) begin
                step();
                m_lfsr = mdl_next(m_lfsr);
                checks++;
                if (rand_out !== 10'd0) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL max%0d_out got %0d expected 0", mi, rand_out);
                end
            end
        end
        for (int n = 0; n < 60; n++) begin
            max = pats[n % 6];
            exp = mdl_scale(m_lfsr, max);
            step();
            m_lfsr = mdl_next(m_lfsr);
            checks++;
            if (rand_out !== exp) begin
                errors++;
                if (errors < 20)
                    $display("FAIL max_change max=%0d got %0d expected %0d", max, rand_out, exp);
            end
        end
    endtask

    task automatic test_mid_reset;
        max = 10'd480;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            step();
            rec[n] = rand_out;
        end
        checks++;
        if (rec[0] !== 10'd323) begin
            errors++;
            $display("FAIL mid_first got %0d expected 323", rec[0]);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (dut.w_lfsr !== 16'hACE1 || rand_out !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_state got %h/%0d expected ace1/0", dut.w_lfsr, rand_out);
        end
        for (int n = 0; n < 1000; n++) begin
            step();
            checks++;
            if (rand_out !== rec[n]) begin
                errors++;
                if (errors < 20)
                    $display("FAIL mid_repeat n=%0d got %0d expected %0d", n, rand_out, rec[n]);
            end
        end
    endtask

`ifdef RANDOM_NUMBER_SEED_LOAD_EN
    task automatic test_seed_load;
        logic [9:0] exp;
        max = 10'd8;
        do_reset();
        step();
        step();
        m_lfsr = mdl_next(mdl_next(m_lfsr));
        exp = mdl_scale(m_lfsr, max);
        seed = 16'h0001;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        checks++;
        if (dut.w_lfsr !== 16'h0001 || rand_out !== exp) begin
            errors++;
            $display("FAIL seed_one got %h/%0d expected 0001/%0d", dut.w_lfsr, rand_out, exp);
        end
        step();
        checks++;
        if (dut.w_lfsr !== 16'h0002) begin
            errors++;
            $display("FAIL seed_one_adv got %h expected 0002", dut.w_lfsr);
        end
        seed = 16'h0000;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        checks++;
        if (dut.w_lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL seed_zero got %h expected ace1", dut.w_lfsr);
        end
        seed = 16'h1234;
        seed_load = 1'b1;
        reset_n = 1'b0;
        step();
        checks++;
        if (dut.w_lfsr !== 16'hACE1 || rand_out !== 10'd0) begin
            errors++;
            $display("FAIL seed_vs_reset got %h/%0d expected ace1/0", dut.w_lfsr, rand_out);
        end
        seed_load = 1'b0;
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_first_values();
        test_range_period();
        test_zero_one_and_changes();
        test_mid_reset();
`ifdef RANDOM_NUMBER_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
